masked_share_encoder: RTL and testbench
=======================================

// Module: masked_share_encoder
// PURPOSE
//  Producer side of the 3-share (order d=2) Boolean masking interface consumed by HPC2 gadgets.
//  Takes one plaintext word plus 2*WIDTH fresh random bits and emits three registered shares:
//    s0 = x ^ r0 ^ r1,  s1 = r0,  s2 = r1.
//  Sits between the unmasked input port of a masked datapath and the first gadget stage.
//  Decouples both sides through a 2-entry share buffer with valid/ready on every side.
// PARAMETERS
//  WIDTH  8   plaintext / per-share bit width
//  CNT_W  16  width of the randomness-starvation counter
// PORTS
//  clock_0          in   1        single clock, rising edge
//  reset_0          in   1        synchronous, active-high reset
//  io_in_data       in   WIDTH    plaintext word x
//  io_in_valid      in   1        x valid
//  io_in_ready      out  1        x accepted when valid&ready
//  p_rand_data      in   2*WIDTH  fresh randomness: [WIDTH-1:0]=r0, [2*WIDTH-1:WIDTH]=r1
//  p_rand_valid     in   1        randomness valid
//  p_rand_ready     out  1        randomness consumed when valid&ready
//  io_o_s0          out  WIDTH    share 0
//  io_o_s1          out  WIDTH    share 1
//  io_o_s2          out  WIDTH    share 2
//  io_o_valid       out  1        share triple valid
//  io_o_ready       in   1        downstream takes triple when valid&ready
//  stat_starve_cnt  out  CNT_W    saturating count of cycles with io_in_valid=1 and p_rand_valid=0
// BEHAVIOUR
//  - Reset (reset_0=1 at a rising edge):
//    - buffer emptied; io_o_valid=0; io_o_s0/s1/s2=0; stat_starve_cnt=0.
//    - io_in_ready=0 and p_rand_ready=0 while reset_0=1; nothing is consumed.
//  - Reset mid-operation flushes buffered triples; they are lost, never emitted later.
//  - Ready generation (full = count==2):
//    - io_in_ready = !full & p_rand_valid
//    - p_rand_ready = !full & io_in_valid
//  - fire = io_in_valid & p_rand_valid & !full
//    - Data and randomness are always consumed together, one random word per plaintext word.
//    - A random word is never reused.
//  - On fire, the encoded triple is written into the buffer at the rising edge; XOR computed
//    before the register.
//  - Latency: fire in cycle t -> io_o_valid=1 in cycle t+1 if buffer was empty.
//  - Throughput: 1 triple/cycle when io_o_ready=1.
//  - Buffer: 2-entry FIFO, one register bank per share index.
//    - pop = io_o_valid & io_o_ready.
//    - count=0: pop impossible, push allowed.
//    - count=1: push+pop same cycle -> count stays 1, order preserved.
//    - count=2: push blocked, pop allowed.
//    - Pointers wrap modulo 2.
//  - Output hygiene:
//    - io_o_s* are driven 0 whenever io_o_valid=0.
//    - A popped entry's storage is cleared to 0 in the same edge.
//    - No stale share data is retained.
//  - Share separation:
//    - After the encode register, no logic combines different share indices.
//    - Read muxes select within one share bank only.
//  - Output stability: io_o_s*/io_o_valid hold constant while io_o_valid=1 & io_o_ready=0.
//  - stat_starve_cnt increments when io_in_valid=1, p_rand_valid=0, reset_0=0.
//    - Saturates at 2^CNT_W-1; no wrap.
//  - FSM implicit in count: EMPTY(0) -> ONE(1) on push; ONE -> TWO on push&!pop;
//    ONE -> EMPTY on pop&!push; TWO -> ONE on pop.
// STRUCTURE
//  - Shared package/include masking_pkg:
//    - NUM_SHARES=3
//    - RAND_WORDS_PER_ENC=2
//    - share index constants S0/S1/S2
//    - share-bus field layout of p_rand_data
//  - Sub-module share_skid_buffer (2-entry, per-share banks, clear-on-pop, zero-when-empty),
//    instanced once with width NUM_SHARES*WIDTH.
//  - Top keeps encode XOR, ready logic and starvation counter.
// TESTING
//  1. Reset, then x=8'hA5, r0=8'h3C, r1=8'h0F, all valid, io_o_ready=1
//     -> next cycle s0=8'h96, s1=8'h3C, s2=8'h0F, io_o_valid=1.
//  2. io_o_ready=0, push 3 words back-to-back
//     -> 2 accepted, io_in_ready=0 on the 3rd;
//     -> release ready: outputs in order, then 3rd accepted.
//  3. io_in_valid=1, p_rand_valid=0 for 5 cycles -> no fire, p_rand_ready=1,
//     io_in_ready=0, stat_starve_cnt=5.
//  4. Count=1 with push+pop in same cycle -> count stays 1;
//     streaming 100 random words at full rate -> 100 triples, each s0^s1^s2 == x.
//  5. Assert reset_0 with 2 entries buffered
//     -> next cycle io_o_valid=0, all shares 0, counter 0, no resurfacing after release.
//  6. CNT_W=4, starve 20 cycles -> stat_starve_cnt=15 (saturated).

Source files
------------

// File: rtl/masking_pkg.sv
// Shared constants for the 3-share Boolean masking interface.
// The randomness bus packs word R0_WORD in its low WIDTH bits and R1_WORD above it.
package masking_pkg;

  localparam int NUM_SHARES         = 3;
  localparam int RAND_WORDS_PER_ENC = 2;

  localparam int S0 = 0;
  localparam int S1 = 1;
  localparam int S2 = 2;

  localparam int R0_WORD = 0;
  localparam int R1_WORD = 1;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/share_skid_buffer.sv
// Two-entry share FIFO with one register bank per share index.
// Popped slots are cleared and outputs are zero while empty.
//
// state     | meaning
// BUF_EMPTY | no triple held, output valid low
// BUF_ONE   | one triple held, push and pop may overlap
// BUF_TWO   | full, push blocked
module share_skid_buffer
  import masking_pkg::*;
#(
  parameter int SHARE_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [NUM_SHARES*SHARE_W-1:0] push_data_i,
  output logic                          full_o,
  input  logic                          pop_ready_i,
  output logic                          out_valid_o,
  output logic [NUM_SHARES*SHARE_W-1:0] out_data_o
);

  buf_state_e state_q, state_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [NUM_SHARES-1:0][1:0][SHARE_W-1:0] bank_q, bank_d;
  logic       push;
  logic       pop;

  assign push = push_i & (state_q != BUF_TWO);
  assign pop  = pop_ready_i & (state_q != BUF_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BUF_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      bank_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      bank_q   <= bank_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case (state_q)
      BUF_EMPTY: if (push) state_d = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_d = BUF_TWO;
        else if (pop && !push) state_d = BUF_EMPTY;
      end
      BUF_TWO:   if (pop) state_d = BUF_ONE;
      default:   state_d = BUF_EMPTY;
    endcase
    // each bank is written and cleared only from its own share slice
    bank_d = bank_q;
    for (int s = 0; s < NUM_SHARES; s++) begin
      if (pop)  bank_d[s][rd_ptr_q] = '0;
      if (push) bank_d[s][wr_ptr_q] = push_data_i[s*SHARE_W +: SHARE_W];
    end
  end

  always_comb begin
    full_o      = (state_q == BUF_TWO);
    out_valid_o = (state_q != BUF_EMPTY);
    out_data_o  = '0;
    for (int s = 0; s < NUM_SHARES; s++) begin
      out_data_o[s*SHARE_W +: SHARE_W] = out_valid_o ? bank_q[s][rd_ptr_q] : '0;
    end
  end

endmodule

// File: rtl/masked_share_encoder.sv
// Encodes a plaintext word into three Boolean shares (x^r0^r1, r0, r1) and buffers them.
// Also counts cycles where plaintext waits on missing randomness.
module masked_share_encoder
  import masking_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                          clock_0,
  input  logic                          reset_0,
  input  logic [WIDTH-1:0]              io_in_data,
  input  logic                          io_in_valid,
  output logic                          io_in_ready,
  input  logic [RAND_WORDS_PER_ENC*WIDTH-1:0] p_rand_data,
  input  logic                          p_rand_valid,
  output logic                          p_rand_ready,
  output logic [WIDTH-1:0]              io_o_s0,
  output logic [WIDTH-1:0]              io_o_s1,
  output logic [WIDTH-1:0]              io_o_s2,
  output logic                          io_o_valid,
  input  logic                          io_o_ready,
  output logic [CNT_W-1:0]              stat_starve_cnt
);

  logic                        full;
  logic                        fire;
  logic [WIDTH-1:0]            r0;
  logic [WIDTH-1:0]            r1;
  logic [NUM_SHARES*WIDTH-1:0] enc;
  logic [NUM_SHARES*WIDTH-1:0] out_data;
  logic [CNT_W-1:0]            starve_cnt_q, starve_cnt_d;

  assign r0 = p_rand_data[R0_WORD*WIDTH +: WIDTH];
  assign r1 = p_rand_data[R1_WORD*WIDTH +: WIDTH];

  assign io_in_ready  = !reset_0 & !full & p_rand_valid;
  assign p_rand_ready = !reset_0 & !full & io_in_valid;
  assign fire         = !reset_0 & !full & io_in_valid & p_rand_valid;

  always_comb begin
    enc                        = '0;
    enc[S0*WIDTH +: WIDTH]     = io_in_data ^ r0 ^ r1;
    enc[S1*WIDTH +: WIDTH]     = r0;
    enc[S2*WIDTH +: WIDTH]     = r1;
  end

  share_skid_buffer #(
    .SHARE_W (WIDTH)
  ) u_buf (
    .clk         (clock_0),
    .rst         (reset_0),
    .push_i      (fire),
    .push_data_i (enc),
    .full_o      (full),
    .pop_ready_i (io_o_ready),
    .out_valid_o (io_o_valid),
    .out_data_o  (out_data)
  );

  assign io_o_s0 = out_data[S0*WIDTH +: WIDTH];
  assign io_o_s1 = out_data[S1*WIDTH +: WIDTH];
  assign io_o_s2 = out_data[S2*WIDTH +: WIDTH];

  // saturating: holds at all-ones instead of wrapping
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (io_in_valid && !p_rand_valid && (starve_cnt_q != {CNT_W{1'b1}}))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clock_0) begin
    if (reset_0) starve_cnt_q <= '0;
    else         starve_cnt_q <= starve_cnt_d;
  end

  assign stat_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_masked_share_encoder.sv
// Scoreboard bench: the driver queues hand-computed share triples on every accepted word,
// and a negedge monitor pops and compares whatever the encoder presents.
module tb_masked_share_encoder;

  logic        clock_0 = 1'b0;
  logic        reset_0;
  logic [7:0]  io_in_data;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [15:0] p_rand_data;
  logic        p_rand_valid;
  logic        p_rand_ready;
  logic [7:0]  io_o_s0, io_o_s1, io_o_s2;
  logic        io_o_valid;
  logic        io_o_ready;
  logic [15:0] stat_starve_cnt;

  logic        rst4;
  logic        iv4, rv4, ir4, rr4, ov4;
  logic [7:0]  s0_4, s1_4, s2_4;
  logic [3:0]  cnt4;

  always #5 clock_0 = ~clock_0;

  masked_share_encoder #(.WIDTH(8), .CNT_W(16)) dut (
    .clock_0(clock_0), .reset_0(reset_0),
    .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .p_rand_data(p_rand_data), .p_rand_valid(p_rand_valid), .p_rand_ready(p_rand_ready),
    .io_o_s0(io_o_s0), .io_o_s1(io_o_s1), .io_o_s2(io_o_s2),
    .io_o_valid(io_o_valid), .io_o_ready(io_o_ready),
    .stat_starve_cnt(stat_starve_cnt)
  );

  masked_share_encoder #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clock_0(clock_0), .reset_0(rst4),
    .io_in_data(8'h00), .io_in_valid(iv4), .io_in_ready(ir4),
    .p_rand_data(16'h0000), .p_rand_valid(rv4), .p_rand_ready(rr4),
    .io_o_s0(s0_4), .io_o_s1(s1_4), .io_o_s2(s2_4),
    .io_o_valid(ov4), .io_o_ready(1'b1),
    .stat_starve_cnt(cnt4)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   cyc    = 0;

  always @(posedge clock_0) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  logic       hold_prev = 1'b0;
  logic [7:0] p0, p1, p2;

  always @(negedge clock_0) begin
    exp_t e;
    if (hold_prev && !reset_0) begin
      checks++;
      if (!io_o_valid || io_o_s0 !== p0 || io_o_s1 !== p1 || io_o_s2 !== p2) begin
        errors++;
        $display("FAIL stall_hold got v=%0b %h/%h/%h required v=1 %h/%h/%h",
                 io_o_valid, io_o_s0, io_o_s1, io_o_s2, p0, p1, p2);
      end
    end
    hold_prev = io_o_valid && !io_o_ready && !reset_0;
    p0 = io_o_s0; p1 = io_o_s1; p2 = io_o_s2;

    if (!io_o_valid && (io_o_s0 != 0 || io_o_s1 != 0 || io_o_s2 != 0)) begin
      checks++;
      errors++;
      $display("FAIL idle_zero got %h/%h/%h required 00/00/00", io_o_s0, io_o_s1, io_o_s2);
    end

    if (io_o_valid && io_o_ready) begin
      pops++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_triple got %h/%h/%h required no output",
                 io_o_s0, io_o_s1, io_o_s2);
      end else begin
        e = exp_q.pop_front();
        if (io_o_s0 !== e.s0 || io_o_s1 !== e.s1 || io_o_s2 !== e.s2) begin
          errors++;
          $display("FAIL triple got %h/%h/%h required %h/%h/%h",
                   io_o_s0, io_o_s1, io_o_s2, e.s0, e.s1, e.s2);
        end
        checks++;
        if ((io_o_s0 ^ io_o_s1 ^ io_o_s2) !== e.x) begin
          errors++;
          $display("FAIL recombine got %h required %h", io_o_s0 ^ io_o_s1 ^ io_o_s2, e.x);
        end
      end
    end
  end

  // Presents one word with its randomness; leaves inputs idle at posedge+1 after acceptance.
  task automatic send(input logic [7:0] x, input logic [7:0] r0, input logic [7:0] r1);
    bit   ok = 0;
    exp_t e;
    io_in_data   = x;
    p_rand_data  = {r1, r0};
    io_in_valid  = 1'b1;
    p_rand_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock_0);
      if (io_in_ready) begin
        e.x = x; e.s0 = x ^ r0 ^ r1; e.s1 = r0; e.s2 = r1;
        exp_q.push_back(e);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got no accept required accept of x=%h", x);
    end
    @(posedge clock_0);
    #1;
    io_in_valid  = 1'b0;
    p_rand_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, pops0;
    reset_0 = 1'b1; rst4 = 1'b1; iv4 = 1'b0; rv4 = 1'b0;
    io_in_data = 8'h00; p_rand_data = 16'h0000;
    io_in_valid = 1'b1; p_rand_valid = 1'b1; io_o_ready = 1'b0;

    // reset: ready low even with both valids high
    @(negedge clock_0);
    check("rst_in_ready", io_in_ready, 0);
    check("rst_rand_ready", p_rand_ready, 0);
    @(posedge clock_0); @(posedge clock_0); #1;
    reset_0 = 1'b0; io_in_valid = 1'b0; p_rand_valid = 1'b0;
    @(negedge clock_0);
    check("rst_o_valid", io_o_valid, 0);
    check("rst_shares", {io_o_s0, io_o_s1, io_o_s2}, 0);
    check("rst_cnt", stat_starve_cnt, 0);

    // single encode, one-cycle latency
    @(posedge clock_0); #1;
    io_o_ready = 1'b1;
    send(8'hA5, 8'h3C, 8'h0F);
    @(negedge clock_0);
    check("latency_valid", io_o_valid, 1);
    check("enc_s0", io_o_s0, 8'h96);
    @(posedge clock_0); #1;

    // starvation: 5 cycles plaintext without randomness
    io_in_valid = 1'b1; p_rand_valid = 1'b0;
    repeat (5) begin
      @(negedge clock_0);
      check("starve_rand_ready", p_rand_ready, 1);
      check("starve_in_ready", io_in_ready, 0);
      @(posedge clock_0);
    end
    #1;
    io_in_valid = 1'b0;
    @(negedge clock_0);
    check("starve_cnt5", stat_starve_cnt, 5);
    @(posedge clock_0); #1;

    // backpressure: two fill the buffer, third waits
    io_o_ready = 1'b0;
    send(8'h11, 8'h22, 8'h33);
    send(8'h44, 8'h55, 8'h66);
    io_in_data = 8'h77; p_rand_data = {8'h99, 8'h88};
    io_in_valid = 1'b1; p_rand_valid = 1'b1;
    repeat (3) begin
      @(negedge clock_0);
      check("full_in_ready", io_in_ready, 0);
      check("full_rand_ready", p_rand_ready, 0);
      check("full_head_s1", io_o_s1, 8'h22);
      @(posedge clock_0); #1;
    end
    io_o_ready = 1'b1;
    send(8'h77, 8'h88, 8'h99);
    repeat (4) @(posedge clock_0);
    #1;
    check("drain_empty", exp_q.size(), 0);

    // full-rate streaming with push+pop overlap at one entry
    t0 = cyc; pops0 = pops;
    for (int i = 0; i < 100; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom));
    check("stream_cycles", cyc - t0, 100);
    repeat (3) @(posedge clock_0);
    #1;
    check("stream_pops", pops - pops0, 100);
    check("stream_drained", exp_q.size(), 0);
    check("cnt_held", stat_starve_cnt, 5);

    // reset with two triples buffered: they must vanish
    io_o_ready = 1'b0;
    send(8'hC3, 8'h5A, 8'hF0);
    send(8'h12, 8'h34, 8'h56);
    @(negedge clock_0);
    check("pre_rst_valid", io_o_valid, 1);
    @(posedge clock_0); #1;
    reset_0 = 1'b1; io_in_valid = 1'b1; p_rand_valid = 1'b1;
    exp_q.delete();
    @(negedge clock_0);
    check("mid_rst_in_ready", io_in_ready, 0);
    check("mid_rst_rand_ready", p_rand_ready, 0);
    @(posedge clock_0); #1;
    io_o_ready = 1'b1;
    @(negedge clock_0);
    check("flush_valid", io_o_valid, 0);
    check("flush_shares", {io_o_s0, io_o_s1, io_o_s2}, 0);
    check("flush_cnt", stat_starve_cnt, 0);
    @(posedge clock_0); #1;
    reset_0 = 1'b0; io_in_valid = 1'b0; p_rand_valid = 1'b0;
    repeat (5) begin
      @(negedge clock_0);
      check("no_resurface", io_o_valid, 0);
    end

    // 4-bit counter saturation
    @(posedge clock_0); #1;
    rst4 = 1'b0; iv4 = 1'b1; rv4 = 1'b0;
    repeat (14) @(posedge clock_0);
    @(negedge clock_0);
    check("cnt4_at14", cnt4, 14);
    repeat (6) @(posedge clock_0);
    @(negedge clock_0);
    check("cnt4_sat", cnt4, 15);
    check("cnt4_in_ready", ir4, 0);
    check("cnt4_rand_ready", rr4, 1);
    check("cnt4_idle", {ov4, s0_4, s1_4, s2_4}, 0);

    check("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
